// File: rtl/rs_add_station.sv
// Integer add/sub reservation station: CDB-snooping entries feed a two-stage
// adder whose result waits in a single broadcast buffer for the CDB grant.
module rs_add_station #(
    parameter int unsigned NUM_ENTRIES = 3,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TAG_W       = 4,
    parameter int unsigned RS_TAG_BASE = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_op,
    input  logic [DATA_W-1:0] issue_vj,
    input  logic [TAG_W-1:0]  issue_qj,
    input  logic [DATA_W-1:0] issue_vk,
    input  logic [TAG_W-1:0]  issue_qk,
    output logic              issue_ready,
    output logic [TAG_W-1:0]  issue_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              status_rs_add,
    input  logic              CTRL_cdb_add,
    output logic [TAG_W-1:0]  out_tag,
    output logic [DATA_W-1:0] out_data
);
    localparam int unsigned IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;

    typedef enum logic [1:0] {ST_FREE, ST_WAIT, ST_READY, ST_EXEC} ent_state_e;

    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] vj;
        logic [TAG_W-1:0]  qj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  qk;
    } ent_t;

    typedef struct packed {
        logic              op;
        logic [DATA_W-1:0] vj;
        logic [DATA_W-1:0] vk;
        logic [TAG_W-1:0]  tag;
    } uop_t;

    ent_state_e st_q  [NUM_ENTRIES];
    ent_state_e st_d  [NUM_ENTRIES];
    ent_t       ent_q [NUM_ENTRIES];
    ent_t       ent_d [NUM_ENTRIES];

    logic              s1_v_q;
    logic              s2_v_q;
    uop_t              s1_q;
    uop_t              s2_q;

    logic              grant_c;
    logic              s2_go_c;
    logic              s1_go_c;
    logic              disp_ok_c;
    logic              cdb_hit_c;
    logic              alloc_hit_c;
    logic [IDX_W-1:0]  alloc_idx_c;
    logic              disp_hit_c;
    logic [IDX_W-1:0]  disp_idx_c;
    logic              do_disp_c;
    logic              issue_fire_c;
    ent_t              issue_ent_c;
    uop_t              disp_uop_c;
    logic              nfree_hit_c;
    logic [IDX_W-1:0]  nfree_idx_c;
    logic [TAG_W-1:0]  issue_tag_d;
    logic [DATA_W-1:0] result_c;

    // Pipeline flow control: a grant only counts while a result is on offer.
    always_comb begin
        grant_c      = status_rs_add & CTRL_cdb_add;
        s2_go_c      = ~status_rs_add | grant_c;
        s1_go_c      = ~s2_v_q | s2_go_c;
        disp_ok_c    = ~s1_v_q | s1_go_c;
        cdb_hit_c    = cdb_valid & (cdb_tag != '0);
        do_disp_c    = disp_hit_c & disp_ok_c;
        issue_fire_c = issue_valid & issue_ready & alloc_hit_c;
        result_c     = s2_q.op ? (s2_q.vj - s2_q.vk) : (s2_q.vj + s2_q.vk);
    end

    // Lowest-index FREE entry for allocation and lowest-index READY for dispatch.
    always_comb begin
        alloc_hit_c = 1'b0;
        alloc_idx_c = '0;
        disp_hit_c  = 1'b0;
        disp_idx_c  = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (st_q[i] == ST_FREE) begin
                alloc_hit_c = 1'b1;
                alloc_idx_c = IDX_W'(i);
            end
            if (st_q[i] == ST_READY) begin
                disp_hit_c = 1'b1;
                disp_idx_c = IDX_W'(i);
            end
        end
    end

    // Incoming instruction with same-cycle CDB bypass applied.
    always_comb begin
        issue_ent_c.op = issue_op;
        issue_ent_c.vj = issue_vj;
        issue_ent_c.qj = issue_qj;
        issue_ent_c.vk = issue_vk;
        issue_ent_c.qk = issue_qk;
        if (cdb_hit_c && (issue_qj == cdb_tag)) begin
            issue_ent_c.vj = cdb_data;
            issue_ent_c.qj = '0;
        end
        if (cdb_hit_c && (issue_qk == cdb_tag)) begin
            issue_ent_c.vk = cdb_data;
            issue_ent_c.qk = '0;
        end
    end

    always_comb begin
        disp_uop_c.op  = ent_q[disp_idx_c].op;
        disp_uop_c.vj  = ent_q[disp_idx_c].vj;
        disp_uop_c.vk  = ent_q[disp_idx_c].vk;
        disp_uop_c.tag = TAG_W'(RS_TAG_BASE) + TAG_W'(disp_idx_c);
    end

    // Per-entry next state.
    always_comb begin
        for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
            st_d[i]  = st_q[i];
            ent_d[i] = ent_q[i];
            case (st_q[i])
                ST_FREE: begin
                    if (issue_fire_c && (alloc_idx_c == IDX_W'(i))) begin
                        ent_d[i] = issue_ent_c;
                        st_d[i]  = ((issue_ent_c.qj == '0) && (issue_ent_c.qk == '0))
                                   ? ST_READY : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cdb_hit_c && (ent_q[i].qj == cdb_tag)) begin
                        ent_d[i].vj = cdb_data;
                        ent_d[i].qj = '0;
                    end
                    if (cdb_hit_c && (ent_q[i].qk == cdb_tag)) begin
                        ent_d[i].vk = cdb_data;
                        ent_d[i].qk = '0;
                    end
                    if ((ent_d[i].qj == '0) && (ent_d[i].qk == '0)) begin
                        st_d[i] = ST_READY;
                    end
                end
                ST_READY: begin
                    if (do_disp_c && (disp_idx_c == IDX_W'(i))) begin
                        st_d[i] = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (grant_c && (out_tag == TAG_W'(RS_TAG_BASE + unsigned'(i)))) begin
                        st_d[i] = ST_FREE;
                    end
                end
                default: st_d[i] = ST_FREE;
            endcase
        end
    end

    // Allocation view for next cycle, so entries freed now are offered next cycle.
    always_comb begin
        nfree_hit_c = 1'b0;
        nfree_idx_c = '0;
        for (int i = int'(NUM_ENTRIES) - 1; i >= 0; i--) begin
            if (st_d[i] == ST_FREE) begin
                nfree_hit_c = 1'b1;
                nfree_idx_c = IDX_W'(i);
            end
        end
        issue_tag_d = nfree_hit_c ? (TAG_W'(RS_TAG_BASE) + TAG_W'(nfree_idx_c)) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                st_q[i]  <= ST_FREE;
                ent_q[i] <= '0;
            end
            issue_ready <= 1'b1;
            issue_tag   <= TAG_W'(RS_TAG_BASE);
        end else begin
            for (int i = 0; i < int'(NUM_ENTRIES); i++) begin
                st_q[i]  <= st_d[i];
                ent_q[i] <= ent_d[i];
            end
            issue_ready <= nfree_hit_c;
            issue_tag   <= issue_tag_d;
        end
    end

    // S1 -> S2 -> broadcast buffer; each stage holds while its successor stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q        <= 1'b0;
            s1_q          <= '0;
            s2_v_q        <= 1'b0;
            s2_q          <= '0;
            status_rs_add <= 1'b0;
            out_tag       <= '0;
            out_data      <= '0;
        end else begin
            if (disp_ok_c) begin
                s1_v_q <= do_disp_c;
                if (do_disp_c) begin
                    s1_q <= disp_uop_c;
                end
            end
            if (s1_go_c) begin
                s2_v_q <= s1_v_q;
                s2_q   <= s1_q;
            end
            if (s2_go_c) begin
                status_rs_add <= s2_v_q;
                out_tag       <= s2_v_q ? s2_q.tag : '0;
                out_data      <= s2_v_q ? result_c : '0;
            end
        end
    end

endmodule

// File: tb/tb_rs_add_station.sv
// Bench for rs_add_station: directed latency/stall/reset scenarios, then
// random issue/CDB/grant traffic against a transaction-level station model.
module tb_rs_add_station;
    localparam int unsigned NE       = 3;
    localparam int unsigned DW       = 32;
    localparam int unsigned TW       = 4;
    localparam int unsigned TAG_BASE = 1;
    localparam int RAND_CYCLES  = 3000;
    localparam int DRAIN_CYCLES = 300;

    logic          clk;
    logic          rst_n;
    logic          issue_valid;
    logic          issue_op;
    logic [DW-1:0] issue_vj;
    logic [TW-1:0] issue_qj;
    logic [DW-1:0] issue_vk;
    logic [TW-1:0] issue_qk;
    logic          issue_ready;
    logic [TW-1:0] issue_tag;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [DW-1:0] cdb_data;
    logic          status_rs_add;
    logic          CTRL_cdb_add;
    logic [TW-1:0] out_tag;
    logic [DW-1:0] out_data;

    rs_add_station #(
        .NUM_ENTRIES(NE), .DATA_W(DW), .TAG_W(TW), .RS_TAG_BASE(TAG_BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .issue_valid(issue_valid), .issue_op(issue_op),
        .issue_vj(issue_vj), .issue_qj(issue_qj),
        .issue_vk(issue_vk), .issue_qk(issue_qk),
        .issue_ready(issue_ready), .issue_tag(issue_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .status_rs_add(status_rs_add), .CTRL_cdb_add(CTRL_cdb_add),
        .out_tag(out_tag), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Station model: one record per entry, operands resolved when tag is 0.
    bit            m_busy [NE];
    bit            m_op   [NE];
    logic [DW-1:0] m_vj   [NE];
    logic [DW-1:0] m_vk   [NE];
    logic [TW-1:0] m_qj   [NE];
    logic [TW-1:0] m_qk   [NE];

    task automatic check_eq(input string nm, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", nm, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_valid  = 1'b0;
        issue_op     = 1'b0;
        issue_vj     = '0;
        issue_qj     = '0;
        issue_vk     = '0;
        issue_qk     = '0;
        cdb_valid    = 1'b0;
        cdb_tag      = '0;
        cdb_data     = '0;
        CTRL_cdb_add = 1'b0;
    endtask

    task automatic drive_issue(input logic op, input logic [31:0] vj, input logic [3:0] qj,
                               input logic [31:0] vk, input logic [3:0] qk);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_vj    = vj;
        issue_qj    = qj;
        issue_vk    = vk;
        issue_qk    = qk;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle_inputs();
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < int'(NE); i++) m_busy[i] = 1'b0;
    endtask

    // Expect the buffer to stay quiet for `quiet` cycles, then show tag/data; grant it.
    task automatic await_bcast(input string nm, input int quiet, input logic [3:0] tag,
                               input logic [31:0] data);
        for (int k = 0; k < quiet; k++) begin
            check_eq({nm, "_quiet"}, 32'(status_rs_add), 32'd0);
            tick();
        end
        check_eq({nm, "_status"}, 32'(status_rs_add), 32'd1);
        check_eq({nm, "_tag"}, 32'(out_tag), 32'(tag));
        check_eq({nm, "_data"}, out_data, data);
        CTRL_cdb_add = 1'b1;
        tick();
        CTRL_cdb_add = 1'b0;
    endtask

    function automatic int m_lowest_free();
        for (int i = 0; i < int'(NE); i++) if (!m_busy[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] m_result(input int i);
        return m_op[i] ? (m_vj[i] - m_vk[i]) : (m_vj[i] + m_vk[i]);
    endfunction

    function automatic logic [31:0] rand_value();
        int r;
        r = $urandom_range(0, 3);
        if (r == 0) return 32'h0;
        if (r == 1) return 32'hFFFF_FFFF;
        return $urandom;
    endfunction

    // Operand is present, waits on an external tag, or waits on a busy station entry.
    task automatic pick_operand(output logic [31:0] v, output logic [3:0] q);
        int r;
        int s;
        r = $urandom_range(0, 3);
        v = rand_value();
        q = 4'd0;
        if (r == 2) begin
            q = 4'(6 + $urandom_range(0, 9));
        end else if (r == 3) begin
            s = $urandom_range(0, int'(NE) - 1);
            for (int k = 0; k < int'(NE); k++) begin
                if (q == 4'd0 && m_busy[(s + k) % int'(NE)]) q = 4'(TAG_BASE + 32'((s + k) % int'(NE)));
            end
        end
    endtask

    logic [31:0] t4_a [3];
    logic [31:0] t4_b [3];
    logic [31:0] t4_r [3];

    initial begin
        int          idx;
        int          alloc;
        int          lf;
        int          busy_cnt;
        int          r;
        bit          drain;
        bit          grant_b;
        bit          ok;
        bit          held;
        logic [3:0]  held_tag;
        logic [31:0] v;
        logic [3:0]  q;

        reset_dut();

        // Reset state.
        check_eq("rst_status", 32'(status_rs_add), 32'd0);
        check_eq("rst_out_tag", 32'(out_tag), 32'd0);
        check_eq("rst_out_data", out_data, 32'd0);
        check_eq("rst_issue_ready", 32'(issue_ready), 32'd1);
        check_eq("rst_issue_tag", 32'(issue_tag), 32'(TAG_BASE));

        // Ready add: result on the buffer four cycles after issue, entry frees on grant.
        drive_issue(1'b0, 32'd5, 4'd0, 32'd7, 4'd0);
        tick();
        idle_inputs();
        check_eq("t1_issue_tag_next", 32'(issue_tag), 32'd2);
        await_bcast("t1", 3, 4'd1, 32'd12);
        check_eq("t1_status_after", 32'(status_rs_add), 32'd0);
        check_eq("t1_ready_after", 32'(issue_ready), 32'd1);
        check_eq("t1_tag_after", 32'(issue_tag), 32'd1);

        // Sub waiting on tag 6, which arrives on the CDB three cycles later.
        drive_issue(1'b1, 32'd0, 4'd6, 32'd3, 4'd0);
        tick();
        idle_inputs();
        tick();
        tick();
        cdb_valid = 1'b1;
        cdb_tag   = 4'd6;
        cdb_data  = 32'd10;
        tick();
        idle_inputs();
        await_bcast("t2", 3, 4'd1, 32'd7);
        drive_issue(1'b1, 32'd0, 4'd0, 32'd1, 4'd0);
        tick();
        idle_inputs();
        await_bcast("t2_wrap", 3, 4'd1, 32'hFFFF_FFFF);

        // Issue-time bypass: tag 6 on the CDB in the issue cycle.
        drive_issue(1'b0, 32'hDEAD, 4'd6, 32'd1, 4'd0);
        cdb_valid = 1'b1;
        cdb_tag   = 4'd6;
        cdb_data  = 32'd9;
        tick();
        idle_inputs();
        await_bcast("t3", 3, 4'd1, 32'd10);

        // Full station with grant withheld, an ignored issue pulse, then back-to-back grants.
        t4_a[0] = 32'd10;  t4_b[0] = 32'd1;   t4_r[0] = 32'd11;
        t4_a[1] = 32'd20;  t4_b[1] = 32'd5;   t4_r[1] = 32'd15;
        t4_a[2] = 32'd100; t4_b[2] = 32'd200; t4_r[2] = 32'd300;
        for (int k = 0; k < 3; k++) begin
            check_eq("t4_ready", 32'(issue_ready), 32'd1);
            check_eq("t4_issue_tag", 32'(issue_tag), 32'(k + 1));
            drive_issue(k == 1, t4_a[k], 4'd0, t4_b[k], 4'd0);
            tick();
        end
        idle_inputs();
        check_eq("t4_full", 32'(issue_ready), 32'd0);
        drive_issue(1'b0, 32'd1, 4'd0, 32'd1, 4'd0);
        tick();
        idle_inputs();
        for (int k = 0; k < 5; k++) begin
            check_eq("t4_stall_status", 32'(status_rs_add), 32'd1);
            check_eq("t4_stall_tag", 32'(out_tag), 32'd1);
            check_eq("t4_stall_data", out_data, 32'd11);
            check_eq("t4_stall_ready", 32'(issue_ready), 32'd0);
            tick();
        end
        CTRL_cdb_add = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check_eq("t4_b2b_status", 32'(status_rs_add), 32'd1);
            check_eq("t4_b2b_tag", 32'(out_tag), 32'(k + 1));
            check_eq("t4_b2b_data", out_data, t4_r[k]);
            if (k == 1) begin
                check_eq("t5_freed_ready", 32'(issue_ready), 32'd1);
                check_eq("t5_freed_tag", 32'(issue_tag), 32'd1);
            end
            tick();
        end
        for (int k = 0; k < 4; k++) begin
            check_eq("t5_no_extra", 32'(status_rs_add), 32'd0);
            tick();
        end
        CTRL_cdb_add = 1'b0;
        check_eq("t5_all_free", 32'(issue_tag), 32'd1);

        // Asynchronous reset in the middle of a stall.
        for (int k = 0; k < 3; k++) begin
            drive_issue(1'b0, 32'(k), 4'd0, 32'd1, 4'd0);
            tick();
        end
        idle_inputs();
        repeat (6) tick();
        check_eq("t6_pre_status", 32'(status_rs_add), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t6_status", 32'(status_rs_add), 32'd0);
        check_eq("t6_out_tag", 32'(out_tag), 32'd0);
        check_eq("t6_out_data", out_data, 32'd0);
        check_eq("t6_ready", 32'(issue_ready), 32'd1);
        check_eq("t6_issue_tag", 32'(issue_tag), 32'(TAG_BASE));
        @(negedge clk);
        rst_n = 1'b1;
        CTRL_cdb_add = 1'b1;
        for (int k = 0; k < 6; k++) begin
            check_eq("t6_discarded", 32'(status_rs_add), 32'd0);
            tick();
        end

        // Random traffic against the model.
        reset_dut();
        held     = 1'b0;
        held_tag = '0;
        for (int cyc = 0; cyc < RAND_CYCLES + DRAIN_CYCLES; cyc++) begin
            drain = (cyc >= RAND_CYCLES);
            lf    = m_lowest_free();

            check_eq("r_issue_ready", 32'(issue_ready), 32'(lf >= 0));
            if (lf >= 0) check_eq("r_issue_tag", 32'(issue_tag), 32'(TAG_BASE) + 32'(lf));
            if (held) begin
                check_eq("r_hold_status", 32'(status_rs_add), 32'd1);
                check_eq("r_hold_tag", 32'(out_tag), 32'(held_tag));
            end

            idx = -1;
            if (status_rs_add === 1'b1) begin
                idx = int'(out_tag) - int'(TAG_BASE);
                ok  = (idx >= 0) && (idx < int'(NE));
                if (ok) ok = m_busy[idx] && (m_qj[idx] == 4'd0) && (m_qk[idx] == 4'd0);
                check_eq("r_bcast_entry", 32'(ok), 32'd1);
                if (ok) check_eq("r_bcast_data", out_data, m_result(idx));
                else idx = -1;
            end

            idle_inputs();
            grant_b      = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
            CTRL_cdb_add = grant_b;
            if (grant_b && idx >= 0) begin
                cdb_valid = 1'b1;
                cdb_tag   = out_tag;
                cdb_data  = m_result(idx);
            end else if (drain) begin
                cdb_valid = 1'b1;
                cdb_tag   = 4'(6 + (cyc % 10));
                cdb_data  = $urandom;
            end else begin
                r        = $urandom_range(0, 5);
                cdb_tag  = 4'($urandom_range(4, 15));
                cdb_data = $urandom;
                if (r <= 1) cdb_valid = 1'b1;
                if (r == 2) begin
                    cdb_valid = 1'b1;
                    cdb_tag   = 4'd0;
                end
            end

            if (!drain && $urandom_range(0, 1) == 1) begin
                issue_valid = 1'b1;
                issue_op    = 1'($urandom_range(0, 1));
                pick_operand(v, q);
                issue_vj = v;
                issue_qj = q;
                pick_operand(v, q);
                issue_vk = v;
                issue_qk = q;
            end

            // Effects of the coming edge on the model.
            alloc = issue_valid ? lf : -1;
            if (cdb_valid && cdb_tag != 4'd0) begin
                for (int i = 0; i < int'(NE); i++) begin
                    if (m_busy[i] && m_qj[i] == cdb_tag) begin
                        m_vj[i] = cdb_data;
                        m_qj[i] = 4'd0;
                    end
                    if (m_busy[i] && m_qk[i] == cdb_tag) begin
                        m_vk[i] = cdb_data;
                        m_qk[i] = 4'd0;
                    end
                end
            end
            if (grant_b && idx >= 0) m_busy[idx] = 1'b0;
            if (alloc >= 0) begin
                m_busy[alloc] = 1'b1;
                m_op[alloc]   = issue_op;
                m_vj[alloc]   = issue_vj;
                m_qj[alloc]   = issue_qj;
                m_vk[alloc]   = issue_vk;
                m_qk[alloc]   = issue_qk;
                if (cdb_valid && cdb_tag != 4'd0 && issue_qj == cdb_tag) begin
                    m_vj[alloc] = cdb_data;
                    m_qj[alloc] = 4'd0;
                end
                if (cdb_valid && cdb_tag != 4'd0 && issue_qk == cdb_tag) begin
                    m_vk[alloc] = cdb_data;
                    m_qk[alloc] = 4'd0;
                end
            end
            held     = (status_rs_add === 1'b1) && !grant_b;
            held_tag = out_tag;
            tick();
        end
        idle_inputs();

        busy_cnt = 0;
        for (int i = 0; i < int'(NE); i++) if (m_busy[i]) busy_cnt++;
        check_eq("r_drained", 32'(busy_cnt), 32'd0);
        check_eq("r_final_status", 32'(status_rs_add), 32'd0);
        check_eq("r_final_ready", 32'(issue_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_add_station.md
Name: rs_add_station

Overview:
Reservation station plus execution pipeline for the integer add/sub functional unit in the Tomasulo core. It holds issued add/sub instructions and snoops the CDB for pending operands. Ready entries are dispatched into a 2-stage adder, and each result is held in a single broadcast buffer. The buffer drives status_rs_add to the CDB arbiter and waits for CTRL_cdb_add before releasing the result onto the CDB.

Parameters:
NUM_ENTRIES, 3, number of station entries (2..8)
DATA_W, 32, operand/result width
TAG_W, 4, producer tag width; tag 0 means "value present"
RS_TAG_BASE, 1, tag of entry 0; entry i owns tag RS_TAG_BASE+i (never 0)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  issue unit presents an instruction
issue_op  in  1  0 = add, 1 = sub (vj - vk)
issue_vj  in  DATA_W  operand j value (valid when issue_qj==0)
issue_qj  in  TAG_W  operand j producer tag
issue_vk  in  DATA_W  operand k value
issue_qk  in  TAG_W  operand k producer tag
issue_ready  out  1  at least one FREE entry
issue_tag  out  TAG_W  tag the accepted instruction will receive (lowest FREE index)
cdb_valid  in  1  CDB carries a result this cycle
cdb_tag  in  TAG_W  CDB result tag
cdb_data  in  DATA_W  CDB result value
status_rs_add  out  1  broadcast buffer holds a result (request to arbiter)
CTRL_cdb_add  in  1  arbiter grant
out_tag  out  TAG_W  broadcast buffer tag
out_data  out  DATA_W  broadcast buffer value

Behaviour:
- Reset (async, rst_n=0): all entries FREE; S1/S2/buffer invalid; status_rs_add=0, out_tag=0, out_data=0; issue_ready=1, issue_tag=RS_TAG_BASE.
- Entry states: FREE -> WAIT (an operand tag nonzero) or READY (both tags 0) on issue; WAIT -> READY when the last pending tag is captured; READY -> EXEC on dispatch; EXEC -> FREE on the edge the entry's result is granted.
- Issue is accepted when issue_valid & issue_ready. The instruction goes to the lowest-index FREE entry. issue_ready and issue_tag are computed from registered state only; an entry freed this cycle is allocatable next cycle.
- CDB capture: every WAIT entry with qj==cdb_tag (or qk) and cdb_valid loads cdb_data and clears the tag at the edge.
- Issue bypass: if an issued operand's tag equals cdb_tag with cdb_valid in the same cycle, the entry stores cdb_data with tag 0.
- cdb_tag==0 never matches.
- Dispatch: at most one per cycle. Picks the lowest-index entry that is READY at cycle start, when S1 is empty or advancing. Carries op, vj, vk and tag into S1.
- Pipeline: S1 -> S2 -> buffer.
  - S2 advances when the buffer is empty or (status_rs_add & CTRL_cdb_add).
  - S1 advances when S2 is empty or advancing.
  - A stalled stage holds its contents unchanged.
- Arithmetic is modulo 2^DATA_W. Computed in S2; no overflow flag.
- Broadcast: status_rs_add = buffer valid; out_tag/out_data are registered buffer contents.
  - A grant in a cycle with status_rs_add=1 completes the broadcast. The buffer clears at the edge, or reloads from S2 at that same edge (back-to-back broadcasts, status stays 1).
  - A grant while status_rs_add=0 is ignored.
  - Buffer contents must not change while status_rs_add=1 and not granted.
- Latency: with both operands present at issue in cycle N and no contention, status_rs_add=1 from cycle N+4.
- The station's own broadcast returns on cdb_*. Entries waiting on that tag capture it normally.
- Reset mid-operation discards all entries and in-flight results.

Test Plan:
- Issue add vj=5, vk=7, q=0 in cycle 0; grant tied to status -> status_rs_add=1 cycle 4, out_tag=1, out_data=12; entry 0 FREE cycle 5.
- Issue sub qj=6, vk=3; cdb_valid, tag 6, data 10 in cycle 3 -> dispatch cycle 4, out_data=7 at cycle 7; sub 0-1 -> out_data=0xFFFFFFFF.
- Issue with qj=6 while the CDB carries tag 6, data 9 in the same cycle -> entry READY next cycle with vj=9, no further wait.
- Hold CTRL_cdb_add=0 for 5 cycles with 3 ready entries -> buffer, S2 and S1 fill and hold stable; issue_ready=0; on grant, three back-to-back broadcasts, tags 1, 2, 3 in order.
- Fill all 3 entries -> issue_ready=0 and an issue_valid pulse is ignored; the granted entry frees and issue_tag equals its tag next cycle.
- Assert rst_n=0 mid-stall, asynchronously between edges -> status_rs_add, out_tag and out_data go to 0 immediately; issue_ready=1.
